// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 constants, class encodings, flag indices and stage-1 bundle
package fp32_pkg;

    localparam int FP32_BIAS  = 127;
    localparam int FP32_EXP_W = 10;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } cls_t;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF   = 32'h7F80_0000;

    // Exponent travels beside this bundle because its width is a module parameter.
    typedef struct packed {
        logic        sign;
        cls_t        cls;
        logic [23:0] mant;
        logic        guard;
        logic        sticky;
    } s1_t;

endpackage

// File: rtl/fp32_mul_norm_round_if.sv
// rtl/fp32_mul_norm_round_if.sv - valid/ready product-in, result-out bus of the normalize/round stage
interface fp32_mul_norm_round_if
    import fp32_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic signed [EXP_W-1:0] in_exp_sum;
    logic [47:0]             in_prod;
    logic [1:0]              in_class;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_result;
    logic [2:0]              out_flags;

    modport master (
        output in_valid, in_sign, in_exp_sum, in_prod, in_class, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp_sum, in_prod, in_class, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp32_round_rne.sv
// rtl/fp32_round_rne.sv - combinational round-to-nearest-even of a 24-bit significand
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [23:0] mant,
    input  logic        guard,
    input  logic        sticky,
    output logic [23:0] mant_out,
    output logic        carry,
    output logic        inexact
);
    logic round_up;

    assign round_up            = guard & (sticky | mant[0]);
    assign {carry, mant_out}   = {1'b0, mant} + {24'd0, round_up};
    assign inexact             = guard | sticky;
endmodule

// File: rtl/fp32_mul_norm_round.sv
// rtl/fp32_mul_norm_round.sv - FP32 product normalize/RNE/pack pipeline; FP32_MUL_SUBNORMAL_EN enables gradual underflow
module fp32_mul_norm_round
    import fp32_pkg::*;
#(
    parameter logic [31:0] CANON_NAN = FP32_CANON_NAN,
    parameter int          EXP_W     = FP32_EXP_W
)(
    input  logic                   clk,
    input  logic                   rst,
    fp32_mul_norm_round_if.slave   bus
);
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(255);

    logic                    s1_valid;
    logic                    s2_valid;
    logic                    s1_adv;
    logic                    in_ready;
    s1_t                     s1_d;
    s1_t                     s1_q;
    logic signed [EXP_W-1:0] s1_exp_d;
    logic signed [EXP_W-1:0] s1_exp_q;
    logic [31:0]             res_d;
    logic [31:0]             res_q;
    logic [2:0]              flags_d;
    logic [2:0]              flags_q;

    assign s1_adv        = !s2_valid || bus.out_ready;
    assign in_ready      = !s1_valid || s1_adv;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;

    always_comb begin
        s1_d.sign = bus.in_sign;
        s1_d.cls  = cls_t'(bus.in_class);
        if (bus.in_prod[47]) begin
            s1_d.mant   = bus.in_prod[47:24];
            s1_d.guard  = bus.in_prod[23];
            s1_d.sticky = |bus.in_prod[22:0];
            s1_exp_d    = bus.in_exp_sum + EXP_ONE;
        end else begin
            s1_d.mant   = bus.in_prod[46:23];
            s1_d.guard  = bus.in_prod[22];
            s1_d.sticky = |bus.in_prod[21:0];
            s1_exp_d    = bus.in_exp_sum;
        end
    end

    logic [23:0]             norm_mant;
    logic                    norm_carry;
    logic                    norm_inexact;
    logic [23:0]             mant_r;
    logic signed [EXP_W-1:0] exp_r;

    fp32_round_rne u_round_norm (
        .mant     (s1_q.mant),
        .guard    (s1_q.guard),
        .sticky   (s1_q.sticky),
        .mant_out (norm_mant),
        .carry    (norm_carry),
        .inexact  (norm_inexact)
    );

    assign mant_r = norm_carry ? 24'h80_0000 : norm_mant;
    assign exp_r  = norm_carry ? s1_exp_q + EXP_ONE : s1_exp_q;

`ifdef FP32_MUL_SUBNORMAL_EN
    logic signed [EXP_W-1:0] sh_raw;
    logic [4:0]              sh;
    logic [50:0]             sh_vec;
    logic [23:0]             sub_mant;
    logic                    sub_carry;
    logic                    sub_inexact;

    // Bits shifted below the guard position land in sh_vec[25:0] and only feed sticky.
    assign sh_raw = EXP_ONE - s1_exp_q;
    assign sh     = (sh_raw > EXP_W'(26)) ? 5'd26 : sh_raw[4:0];
    assign sh_vec = {s1_q.mant, s1_q.guard, 26'd0} >> sh;

    fp32_round_rne u_round_sub (
        .mant     (sh_vec[50:27]),
        .guard    (sh_vec[26]),
        .sticky   (s1_q.sticky | (|sh_vec[25:0])),
        .mant_out (sub_mant),
        .carry    (sub_carry),
        .inexact  (sub_inexact)
    );
`endif

    always_comb begin
        res_d             = {s1_q.sign, exp_r[7:0], mant_r[22:0]};
        flags_d           = '0;
        flags_d[FLAG_INX] = norm_inexact;
        if (s1_exp_q <= EXP_ZERO) begin
`ifdef FP32_MUL_SUBNORMAL_EN
            // A round-up into bit 23 promotes the result to the smallest normal.
            res_d             = {s1_q.sign, 7'd0, sub_mant[23] | sub_carry, sub_mant[22:0]};
            flags_d[FLAG_UNF] = sub_inexact;
            flags_d[FLAG_INX] = sub_inexact;
`else
            res_d             = {s1_q.sign, 31'd0};
            flags_d[FLAG_UNF] = 1'b1;
            flags_d[FLAG_INX] = 1'b1;
`endif
        end else if (exp_r >= EXP_INF) begin
            res_d             = {s1_q.sign, FP32_POS_INF[30:0]};
            flags_d[FLAG_OVF] = 1'b1;
            flags_d[FLAG_INX] = 1'b1;
        end
        case (s1_q.cls)
            CLS_ZERO: begin
                res_d   = {s1_q.sign, 31'd0};
                flags_d = '0;
            end
            CLS_INF: begin
                res_d   = {s1_q.sign, FP32_POS_INF[30:0]};
                flags_d = '0;
            end
            CLS_NAN: begin
                res_d   = CANON_NAN;
                flags_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    res_q   <= res_d;
                    flags_q <= flags_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && bus.in_valid) begin
            s1_q     <= s1_d;
            s1_exp_q <= s1_exp_d;
        end
    end
endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// tb/tb_fp32_mul_norm_round.sv - table-driven checks of fp32_mul_norm_round
module tb_fp32_mul_norm_round;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp32_mul_norm_round_if #(.EXP_W(10)) bus ();

    fp32_mul_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic               sign;
        logic signed [9:0]  exp_sum;
        logic [47:0]        prod;
        logic [1:0]         cls;
        logic [31:0]        res;
        logic [2:0]         flags;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic s, input int es, input logic [47:0] p,
                                input logic [1:0] c, input logic [31:0] r, input logic [2:0] f);
        vec_t v;
        v.sign    = s;
        v.exp_sum = es[9:0];
        v.prod    = p;
        v.cls     = c;
        v.res     = r;
        v.flags   = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        bus.in_sign    = vecs[i].sign;
        bus.in_exp_sum = vecs[i].exp_sum;
        bus.in_prod    = vecs[i].prod;
        bus.in_class   = vecs[i].cls;
    endtask

    task automatic run_stream(input int first, input int cnt, input int stall, output int acc_stall);
        int in_i = 0;
        int out_i = 0;
        int cyc = 0;
        logic [31:0] held = '0;
        logic held_v = 1'b0;
        acc_stall = 0;
        while (out_i < cnt && cyc < 300) begin
            @(negedge clk);
            bus.in_valid  = (in_i < cnt);
            if (in_i < cnt) drive(first + in_i);
            bus.out_ready = (cyc >= stall);
            #1;
            if (stall >= 4 && cyc == stall - 1)
                chk("in_ready_stalled", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid && !bus.out_ready) begin
                if (held_v) chk("stall_stable", bus.out_result, held);
                held   = bus.out_result;
                held_v = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("res[%0d]", first + out_i), bus.out_result, vecs[first + out_i].res);
                chk($sformatf("flags[%0d]", first + out_i), {29'd0, bus.out_flags},
                    {29'd0, vecs[first + out_i].flags});
                out_i++;
            end
            if (bus.in_valid && bus.in_ready) begin
                in_i++;
                if (cyc < stall) acc_stall++;
            end
            cyc++;
        end
        if (out_i < cnt) chk("stream_timeout", out_i, cnt);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("no_duplicate", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        vecs[0]  = mk(1'b0, 127, 48'h4000_0000_0000, 2'b00, 32'h3F80_0000, 3'b000);
        vecs[1]  = mk(1'b0, 127, 48'h9000_0000_0000, 2'b00, 32'h4010_0000, 3'b000);
        vecs[2]  = mk(1'b0, 127, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 3'b001);
        vecs[3]  = mk(1'b0, 127, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 3'b001);
        vecs[4]  = mk(1'b0, 127, 48'h4000_0040_0001, 2'b00, 32'h3F80_0001, 3'b001);
        vecs[5]  = mk(1'b0, 127, 48'hFFFF_FF80_0000, 2'b00, 32'h4080_0000, 3'b001);
        vecs[6]  = mk(1'b0, 254, 48'h8000_0000_0000, 2'b00, 32'h7F80_0000, 3'b101);
        vecs[7]  = mk(1'b0, 253, 48'hFFFF_FF80_0000, 2'b00, 32'h7F80_0000, 3'b101);
        vecs[8]  = mk(1'b0, 253, 48'h8000_0000_0000, 2'b00, 32'h7F00_0000, 3'b000);
        vecs[9]  = mk(1'b0, 127, 48'h4000_0000_0000, 2'b11, 32'h7FC0_0000, 3'b000);
        vecs[10] = mk(1'b1, 127, 48'h4000_0000_0000, 2'b10, 32'hFF80_0000, 3'b000);
        vecs[11] = mk(1'b1, 127, 48'h0000_0000_0000, 2'b01, 32'h8000_0000, 3'b000);
        vecs[12] = mk(1'b1, 127, 48'h4000_0000_0000, 2'b00, 32'hBF80_0000, 3'b000);
        vecs[13] = mk(1'b0, 0,   48'h0000_0000_0000, 2'b01, 32'h0000_0000, 3'b000);
        vecs[14] = mk(1'b0, -127, 48'h4000_0000_0000, 2'b00, 32'h0000_0000, 3'b011);
`ifdef FP32_MUL_SUBNORMAL_EN
        vecs[15] = mk(1'b0, 0,   48'h4000_0000_0000, 2'b00, 32'h0040_0000, 3'b000);
        vecs[16] = mk(1'b0, -1,  48'h6000_0000_0000, 2'b00, 32'h0030_0000, 3'b000);
        vecs[17] = mk(1'b0, 0,   48'h4000_00C0_0000, 2'b00, 32'h0040_0001, 3'b011);
        vecs[18] = mk(1'b0, 0,   48'h7FFF_FFC0_0000, 2'b00, 32'h0080_0000, 3'b011);
`else
        vecs[15] = mk(1'b0, 0,   48'h4000_0000_0000, 2'b00, 32'h0000_0000, 3'b011);
        vecs[16] = mk(1'b0, -1,  48'h6000_0000_0000, 2'b00, 32'h0000_0000, 3'b011);
        vecs[17] = mk(1'b0, 0,   48'h4000_00C0_0000, 2'b00, 32'h0000_0000, 3'b011);
        vecs[18] = mk(1'b0, 0,   48'h7FFF_FFC0_0000, 2'b00, 32'h0000_0000, 3'b011);
`endif

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_flags", {29'd0, bus.out_flags}, 32'd0);

        // Latency: transfer edge, then result visible after the following edge.
        @(negedge clk);
        drive(0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("lat_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("lat_cycle1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat_cycle2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_result", bus.out_result, 32'h3F80_0000);

        run_stream(0, NV, 0, acc);

        run_stream(0, 3, 4, acc);
        chk("accepted_during_stall", acc, 2);

        // Reset with both stages occupied.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        run_stream(3, 1, 0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
